// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED counter controller.
//   state_e : run/stop FSM encoding (STOP = 0, RUN = 1)
//   SPEED_W : width of the speed index
//   LED_W   : width of the count / LED bus
package led_ctrl_pkg;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int SPEED_W = 2;
  localparam int LED_W   = 16;

endpackage : led_ctrl_pkg

// File: rtl/btn_debounce.sv
// Pushbutton front end: two-flop synchroniser, debounce counter and
// rising-edge press detector.
//   clk     : clock
//   rst     : synchronous active-high reset
//   btn_raw : raw asynchronous button level
//   press   : one-cycle pulse on each accepted 0->1 transition
module btn_debounce #(
  parameter int DEBOUNCE_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  logic                  sync_meta;
  logic                  sync_lvl;
  logic                  stable;
  logic                  stable_d;
  logic [DEBOUNCE_W-1:0] cnt;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_lvl  <= 1'b0;
      stable    <= 1'b0;
      stable_d  <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync_lvl  <= sync_meta;
      stable_d  <= stable;
      // Any return to the accepted level restarts the stability window.
      if (sync_lvl == stable) begin
        cnt <= '0;
      end else if (cnt == '1) begin
        stable <= sync_lvl;
        cnt    <= '0;
      end else begin
        cnt <= cnt + DEBOUNCE_W'(1);
      end
    end
  end

  // Releases (1->0) are ignored; only new presses pulse.
  assign press = stable & ~stable_d;

endmodule : btn_debounce

// File: rtl/led_counter_ctrl.sv
// User-controlled 16-bit up/down LED counter.
//   clk       : clock
//   rst       : synchronous active-high reset
//   btn_run   : raw button, toggles run/stop
//   btn_dir   : raw button, toggles count direction
//   btn_speed : raw button, cycles speed 0..3
//   btn_clr   : raw button, clears count and prescaler
//   led       : registered count value
//   running   : high while in RUN
//   dir_down  : 0 = count up, 1 = count down
//   speed     : current speed index (tick period 2^(PRESC_W-speed))
module led_counter_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int PRESC_W    = 23,
  parameter int DEBOUNCE_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_run,
  input  logic               btn_dir,
  input  logic               btn_speed,
  input  logic               btn_clr,
  output logic [LED_W-1:0]   led,
  output logic               running,
  output logic               dir_down,
  output logic [SPEED_W-1:0] speed
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = '1;

  logic run_press, dir_press, speed_press, clr_press;

  btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_db_run (
    .clk(clk), .rst(rst), .btn_raw(btn_run), .press(run_press)
  );
  btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_db_dir (
    .clk(clk), .rst(rst), .btn_raw(btn_dir), .press(dir_press)
  );
  btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_db_speed (
    .clk(clk), .rst(rst), .btn_raw(btn_speed), .press(speed_press)
  );
  btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_db_clr (
    .clk(clk), .rst(rst), .btn_raw(btn_clr), .press(clr_press)
  );

  state_e               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q;
  logic [PRESC_W-1:0]   presc_limit;
  logic [LED_W-1:0]     count_q;
  logic                 dir_q;
  logic [SPEED_W-1:0]   speed_q;
  logic                 tick;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= STOP;
    else     state_q <= state_d;
  end

  // FSM next state: a run press toggles between STOP and RUN
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (run_press) state_d = (state_q == RUN) ? STOP : RUN;
  end

  // FSM outputs
  always_comb begin
    running = (state_q == RUN);
  end

  // P-1 = 2^(PRESC_W-speed)-1, i.e. the all-ones value shifted down by speed.
  assign presc_limit = PRESC_MAX >> speed_q;
  assign tick        = (state_q == RUN) && (presc_q == presc_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
      speed_q <= '0;
    end else begin
      if (dir_press)   dir_q   <= ~dir_q;
      if (speed_press) speed_q <= speed_q + SPEED_W'(1);

      // Clear and speed change restart the interval; STOP holds the prescaler
      // so a resumed run finishes the interval already in progress.
      if (clr_press || speed_press) begin
        presc_q <= '0;
      end else if (state_q == RUN) begin
        presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
      end

      // Clear beats tick; a tick coinciding with a speed change is dropped.
      // The old direction applies to a tick in the same cycle as a dir press.
      if (clr_press) begin
        count_q <= '0;
      end else if (tick && !speed_press) begin
        count_q <= dir_q ? count_q - LED_W'(1) : count_q + LED_W'(1);
      end
    end
  end

  assign led      = count_q;
  assign dir_down = dir_q;
  assign speed    = speed_q;

endmodule : led_counter_ctrl

// File: tb/tb_led_counter_ctrl.sv
// Directed self-checking bench for led_counter_ctrl (PRESC_W=4, DEBOUNCE_W=2).
// Times are edge numbers A<n> counted from the first run press; a button held
// high from A<s> is acted on at A<s+7>.
module tb_led_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_run = 1'b0;
  logic        btn_dir = 1'b0;
  logic        btn_speed = 1'b0;
  logic        btn_clr = 1'b0;
  logic [15:0] led;
  logic        running;
  logic        dir_down;
  logic [1:0]  speed;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;

  led_counter_ctrl #(.PRESC_W(4), .DEBOUNCE_W(2)) dut (
    .clk(clk), .rst(rst),
    .btn_run(btn_run), .btn_dir(btn_dir), .btn_speed(btn_speed), .btn_clr(btn_clr),
    .led(led), .running(running), .dir_down(dir_down), .speed(speed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after edge A<a>.
  task automatic at(input int a);
    while (cyc - base < a) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_run   = v;
      1: btn_dir   = v;
      2: btn_speed = v;
      default: btn_clr = v;
    endcase
  endtask

  // Hold a button from A<s> until its effect edge A<s+7>, then release.
  task automatic press(input int b, input int s);
    at(s);
    set_btn(b, 1'b1);
    at(s + 7);
    set_btn(b, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // 1. Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_led", led, 32'h0);
    check("rst_running", running, 0);
    check("rst_dir", dir_down, 0);
    check("rst_speed", speed, 0);
    repeat (100) @(posedge clk);
    #1;
    check("idle_led", led, 32'h0);
    check("idle_running", running, 0);

    // 2. Run and count: 10-cycle hold gives one press at A7
    base = cyc;
    btn_run = 1'b1;
    at(6);  check("run_before_e7", running, 0);
    at(7);  check("run_at_e7", running, 1);
    at(10); btn_run = 1'b0;
    at(22); check("cnt_a22", led, 32'h0);
    at(23); check("cnt_a23", led, 32'h1);
    at(38); check("cnt_a38", led, 32'h1);
    at(39); check("cnt_a39", led, 32'h2);
    at(55); check("cnt_a55", led, 32'h3);
    press(0, 55);
    check("stop_running", running, 0);
    check("stop_led", led, 32'h3);
    at(102); check("stop_hold", led, 32'h3);

    // 3. Speed presses while running (prescaler held at 7 while stopped)
    press(0, 102);
    check("rerun_running", running, 1);
    press(2, 109);
    check("spd1", speed, 1);
    check("spd1_led", led, 32'h3);
    press(2, 122);
    check("spd2", speed, 2);
    check("spd2_led", led, 32'h4);
    press(2, 135);
    check("spd3", speed, 3);
    check("spd3_led", led, 32'h7);
    at(143); check("spd3_a143", led, 32'h7);
    at(144); check("spd3_a144", led, 32'h8);
    at(146); check("spd3_a146", led, 32'h9);
    press(2, 148);
    check("spd0_wrap", speed, 0);
    check("spd0_led", led, 32'hd);
    at(170); check("spd0_a170", led, 32'hd);
    at(171); check("spd0_a171", led, 32'he);

    // 4. Clear, then count down through zero, then up through 0xFFFF
    press(3, 171);
    check("clr_led", led, 32'h0);
    check("clr_running", running, 1);
    press(1, 178);
    check("dir_down_set", dir_down, 1);
    at(193); check("down_a193", led, 32'h0);
    at(194); check("down_wrap", led, 32'hffff);
    at(210); check("down_a210", led, 32'hfffe);
    press(1, 210);
    check("dir_up_set", dir_down, 0);
    at(226); check("up_a226", led, 32'hffff);
    at(242); check("up_wrap", led, 32'h0);

    // 5. Clear coinciding with the tick at led=5
    at(322); check("pre_clr_led", led, 32'h5);
    press(3, 331);
    check("clr_prio_led", led, 32'h0);
    check("clr_prio_running", running, 1);
    at(354); check("post_clr_a354", led, 32'h1);

    // Run->STOP press coinciding with a tick still counts
    press(0, 363);
    check("stop_tick_running", running, 0);
    check("stop_tick_led", led, 32'h2);
    at(390); check("stop_tick_hold", led, 32'h2);

    // Speed press coinciding with a tick drops the tick
    press(0, 390);
    check("rerun2_running", running, 1);
    press(2, 406);
    check("spd_tick_lost", led, 32'h2);
    check("spd_tick_speed", speed, 1);
    at(420); check("spd_tick_a420", led, 32'h2);
    at(421); check("spd_tick_a421", led, 32'h3);

    // 6. Glitch rejection: 3-cycle run pulse
    btn_run = 1'b1;
    at(424); btn_run = 1'b0;
    at(434);
    check("glitch_running", running, 1);
    check("glitch_led", led, 32'h4);

    // Reset mid-run at led=9
    at(469); check("pre_rst_led", led, 32'h9);
    rst = 1'b1;
    at(470);
    check("midrst_led", led, 32'h0);
    check("midrst_running", running, 0);
    check("midrst_dir", dir_down, 0);
    check("midrst_speed", speed, 0);
    rst = 1'b0;
    at(490);
    check("post_rst_led", led, 32'h0);
    check("post_rst_running", running, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_led_counter_ctrl

// File: doc/led_counter_ctrl.md
# led_counter_ctrl

Controller for the board's 16-LED binary counter display. It takes four raw pushbuttons (run/pause, direction, speed, clear) and synchronises, debounces and edge-detects each one. It then sequences a 16-bit up/down counter through a run/stop state machine with a selectable prescaled tick, and drives the count directly onto the LEDs. It sits between the board buttons and the `led` pins and replaces the free-running counter with a user-controlled one.

## Interface
- `PRESC_W`, default 23: prescaler width. At speed 0, the tick period is 2^PRESC_W cycles.
- `DEBOUNCE_W`, default 20: a button must be stable for 2^DEBOUNCE_W cycles before it is accepted.
- `clk`  in  1: single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `btn_run`  in  1: raw, asynchronous button that toggles run/stop.
- `btn_dir`  in  1: raw button that toggles count direction.
- `btn_speed`  in  1: raw button that cycles speed 0→1→2→3→0.
- `btn_clr`  in  1: raw button that clears the count.
- `led`  out  16: registered count value.
- `running`  out  1: high in state RUN.
- `dir_down`  out  1: 0 = count up, 1 = count down.
- `speed`  out  2: current speed index.

## Operation
- **Reset values** (applied at the clock edge where `rst` is high):
  - `led` = 0, `running` = 0, `dir_down` = 0, `speed` = 0.
  - Prescaler = 0, FSM = STOP.
  - Debouncer stable levels = 0 and counters = 0. No press pulses are emitted.
  - Reset mid-operation overrides everything in the same cycle.
- **Button front end** (one per button):
  - Two-flop synchroniser.
  - The debounce counter resets to 0 whenever the synchronised level equals the stable level. Otherwise it increments.
  - When the counter reaches 2^DEBOUNCE_W−1 with the levels still differing, the stable level takes the synchronised level and the counter clears.
  - A one-cycle press pulse is emitted on each 0→1 transition of the stable level. Releases produce no pulse.
  - A glitch shorter than 2^DEBOUNCE_W cycles produces no pulse.
- **FSM states:**
  - STOP: the count and prescaler hold.
  - RUN: the prescaler advances each cycle.
- **FSM transitions:**
  - A run press in STOP moves to RUN.
  - A run press in RUN moves to STOP.
  - No other transitions exist.
- **Prescaler and tick:**
  - The tick period is P = 2^(PRESC_W−speed) cycles.
  - In RUN, the prescaler counts 0..P−1 and asserts tick when it equals P−1, then returns to 0.
  - In STOP, the prescaler holds its value, so a resumed run completes the remaining interval.
- **Count:**
  - On tick, the count becomes count+1 when up and count−1 when down, modulo 2^16.
  - Wrap-around: 0xFFFF→0x0000 up, and 0x0000→0xFFFF down.
- **Direction press:** toggles `dir_down` in any state. It takes effect from the next tick.
- **Speed press:** `speed` becomes (speed+1) mod 4 in any state, and the prescaler clears to 0.
- **Clear press:** the count and prescaler become 0. The FSM state, `dir_down` and `speed` are unchanged.
- **Simultaneous events in one cycle:**
  - `rst` has the highest priority.
  - Clear beats tick, so the count becomes 0, not 0±1.
  - Speed-press clearing of the prescaler beats tick; the tick is lost.
  - The run toggle and the other presses are independent and all apply.
  - A tick coinciding with a run→STOP press still updates the count, because the tick was generated in RUN.

## Timing
- **Press-pulse timing:** for a button that is high from before clock edge E1:
  - the synchroniser output is high after E2;
  - the stable level flips at edge E(2+2^DEBOUNCE_W);
  - the press pulse is high during the following cycle;
  - the controller acts at the next edge.
- **Press-to-effect latency:** 3+2^DEBOUNCE_W edges.
- **Tick-to-display latency:** a tick asserted in cycle n updates `led` at the edge ending cycle n. There is no extra output latency.
- **Status outputs:** `running`, `dir_down` and `speed` are registered and update at the same edge as their state change.

## Structure
- **Shared header/package `led_ctrl_pkg`:**
  - FSM state encodings: STOP = 1'b0, RUN = 1'b1.
  - Speed width (2).
  - LED width (16).
- **Sub-module `btn_debounce`**, parameter `DEBOUNCE_W`:
  - Ports: `clk`, `rst`, `btn_raw`, `press`.
  - Contains the synchroniser, debounce counter and rising-edge pulse.
  - Instantiated four times.
- The top level holds the FSM, prescaler, direction/speed registers and count register.

## Test plan
All tests use PRESC_W=4 and DEBOUNCE_W=2.
1. **Reset:** assert `rst` for 2 cycles with buttons low → `led`=0x0000, `running`=0, `dir_down`=0, `speed`=0. Hold for 100 cycles → no change.
2. **Run and count:** hold `btn_run` high for 10 cycles → exactly one press, `running`=1 at edge 7. Then `led` steps 1, 2, 3 at 16-cycle intervals. A second press → `running`=0 and `led` holds.
3. **Speed:** three speed presses while running → `speed`=3, and `led` increments every 2 cycles. A fourth press → `speed`=0 and the period returns to 16.
4. **Direction wrap:** clear, then press dir while running → `led` goes 0x0000→0xFFFF→0xFFFE on consecutive ticks. Force 0xFFFF counting up → next value 0x0000.
5. **Clear priority:** a clear press timed to coincide with a tick at `led`=0x0005 → `led`=0x0000 and `running` stays 1.
6. **Glitch rejection and reset mid-run:** a 3-cycle `btn_run` pulse → no state change. Assert `rst` while running at `led`=0x0009 → all outputs 0 at the next edge.
